// File: rtl/ws2812_rx_pkg.sv
// Shared types and default 100 MHz timing for the WS2812 receiver.
package ws2812_pkg;

  // Default timing in 100 MHz system-clock cycles.
  localparam int WS_T_BIT_THRESH   = 60;    // 0.6 us: high width at/above this is a 1
  localparam int WS_T_MAX_HIGH     = 150;   // 1.5 us: high width treated as a line fault
  localparam int WS_T_LATCH        = 5000;  // 50 us: low gap that ends a frame
  localparam int WS_BITS_PER_PIXEL = 24;
  localparam int WS_PX_COUNT_WIDTH = 6;

  // Receiver FSM states. SYNC is the reset state and the fault-recovery state.
  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } ws_state_e;

endpackage

// File: rtl/ws2812_rx_if.sv
// Output bundle of the WS2812 receiver.
//
// Strobe semantics: pixel_valid, frame_done and bit_err are single-cycle
// strobes with no ready/back-pressure. pixel and pixel_idx are meaningful in
// the cycle pixel_valid is high; pixel holds its value between strobes.
// bit_err and frame_done may be high in the same cycle (partial word at the
// latch gap). state mirrors the receiver FSM for observation.
interface ws2812_rx_if #(
  parameter int BPP  = ws2812_pkg::WS_BITS_PER_PIXEL,
  parameter int IDXW = ws2812_pkg::WS_PX_COUNT_WIDTH
);
  logic [BPP-1:0]        pixel;
  logic                  pixel_valid;
  logic [IDXW-1:0]       pixel_idx;
  logic                  frame_done;
  logic                  bit_err;
  ws2812_pkg::ws_state_e state;

  modport master (
    output pixel, pixel_valid, pixel_idx, frame_done, bit_err, state
  );

  modport slave (
    input pixel, pixel_valid, pixel_idx, frame_done, bit_err, state
  );
endinterface

// File: rtl/ws2812_rx_sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops; only q is used downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: classifies high pulses into bits, packs them
// MSB-first into pixel words and detects the latch gap that ends a frame.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int BIT_THRESH     = WS_T_BIT_THRESH,
  parameter int MAX_HIGH       = WS_T_MAX_HIGH,
  parameter int LATCH_CYCLES   = WS_T_LATCH,
  parameter int BITS_PER_PIXEL = WS_BITS_PER_PIXEL,
  parameter int PX_COUNT_WIDTH = WS_PX_COUNT_WIDTH
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       din,
  ws2812_rx_if.master rx
);

  localparam int CNT_W = $clog2(LATCH_CYCLES + 1);
  localparam int BC_W  = $clog2(BITS_PER_PIXEL + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] CNT_LATCH  = CNT_W'(LATCH_CYCLES);
  localparam logic [BC_W-1:0]  BC_FULL    = BC_W'(BITS_PER_PIXEL);
  localparam logic [BC_W-1:0]  BC_ONE     = BC_W'(1);
  localparam logic [PX_COUNT_WIDTH-1:0] IDX_ONE = PX_COUNT_WIDTH'(1);

  // Synchronized line and edge detection.
  logic s;
  logic s_prev;
  logic rise;
  logic fall;

  // Level-width counter and FSM.
  logic [CNT_W-1:0] cnt;
  ws_state_e        state;
  ws_state_e        state_d;

  // FSM decisions consumed by the datapath.
  logic shift_en;
  logic shift_bit;
  logic frame_end;
  logic fault;
  logic frame_done_d;
  logic bit_err_d;

  // Word assembly.
  logic [BITS_PER_PIXEL-1:0] shreg;
  logic [BC_W-1:0]           bit_cnt;
  logic                      got_bit;

  // Registered outputs.
  logic [BITS_PER_PIXEL-1:0] pixel_q;
  logic                      pixel_valid_q;
  logic [PX_COUNT_WIDTH-1:0] pixel_idx_q;
  logic                      frame_done_q;
  logic                      bit_err_q;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (din),
    .q       (s)
  );

  // Previous synchronized level, for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s_prev <= 1'b0;
    else          s_prev <= s;
  end

  assign rise = s & ~s_prev;
  assign fall = ~s & s_prev;

  // Width of the current level of s. The edge cycle itself counts as the
  // first cycle, so a pulse N cycles wide reads cnt = N in the cycle its
  // trailing edge is seen. Saturates at the latch length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            cnt <= '0;
    else if (rise || fall)   cnt <= CNT_ONE;
    else if (cnt != CNT_LATCH) cnt <= cnt + CNT_ONE;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SYNC;
    else          state <= state_d;
  end

  // FSM next state and per-cycle decisions.
  always_comb begin
    state_d   = state;
    shift_en  = 1'b0;
    shift_bit = (cnt >= CNT_THRESH);
    frame_end = 1'b0;
    fault     = 1'b0;
    case (state)
      SYNC: begin
        // Only a full quiet gap proves we are at a frame boundary.
        if (!s && cnt == CNT_LATCH) state_d = IDLE;
      end
      IDLE: begin
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        // A pulse reaching MAX_HIGH is a fault even if it ends this cycle.
        if (cnt >= CNT_MAX) begin
          fault   = 1'b1;
          state_d = SYNC;
        end else if (fall) begin
          shift_en = 1'b1;
          state_d  = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (cnt == CNT_LATCH) begin
          frame_end = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  assign frame_done_d = frame_end & got_bit;
  assign bit_err_d    = fault | (frame_end & (bit_cnt != '0));

  // Word assembly, pixel index and output strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg         <= '0;
      bit_cnt       <= '0;
      got_bit       <= 1'b0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      pixel_idx_q   <= '0;
      frame_done_q  <= 1'b0;
      bit_err_q     <= 1'b0;
    end else begin
      pixel_valid_q <= 1'b0;
      frame_done_q  <= frame_done_d;
      bit_err_q     <= bit_err_d;
      if (state == SYNC || state == IDLE || fault || frame_end) begin
        // Frame boundary or fault: drop any partial word, restart indexing.
        bit_cnt     <= '0;
        pixel_idx_q <= '0;
        got_bit     <= 1'b0;
      end else begin
        if (shift_en) begin
          shreg   <= {shreg[BITS_PER_PIXEL-2:0], shift_bit};
          bit_cnt <= bit_cnt + BC_ONE;
          got_bit <= 1'b1;
        end else if (bit_cnt == BC_FULL) begin
          pixel_q       <= shreg;
          pixel_valid_q <= 1'b1;
          bit_cnt       <= '0;
        end
        // Index advances the cycle after its strobe so the strobe carries
        // the index of the word it presents.
        if (pixel_valid_q) pixel_idx_q <= pixel_idx_q + IDX_ONE;
      end
    end
  end

  assign rx.pixel       = pixel_q;
  assign rx.pixel_valid = pixel_valid_q;
  assign rx.pixel_idx   = pixel_idx_q;
  assign rx.frame_done  = frame_done_q;
  assign rx.bit_err     = bit_err_q;
  assign rx.state       = state;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: directed WS2812 waveforms, expected strobes queued
// by the stimulus and checked by an independent monitor.
module tb_ws2812_rx;
  import ws2812_pkg::*;

  localparam int BPP   = 24;
  localparam int IDXW  = 6;
  localparam int W     = BPP + IDXW + 3;
  localparam int LATCH = 5000;
  localparam int GAP   = LATCH + 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic din = 1'b0;

  ws2812_rx_if #(.BPP(BPP), .IDXW(IDXW)) rx_if ();

  ws2812_rx #(
    .BIT_THRESH     (60),
    .MAX_HIGH       (150),
    .LATCH_CYCLES   (LATCH),
    .BITS_PER_PIXEL (BPP),
    .PX_COUNT_WIDTH (IDXW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (din),
    .rx      (rx_if)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // Event word: {bit_err, frame_done, pixel_valid, idx, pixel}.
  function automatic logic [W-1:0] mk_ev(input logic err, input logic fd,
                                         input logic pv,
                                         input logic [IDXW-1:0] idx,
                                         input logic [BPP-1:0] px);
    return {err, fd, pv, idx, px};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every strobe cycle is compared against the next queued event.
  logic [W-1:0] obs;
  logic [W-1:0] exp_v;
  always @(negedge clk) begin
    if (rx_if.pixel_valid || rx_if.frame_done || rx_if.bit_err) begin
      obs = {rx_if.bit_err, rx_if.frame_done, rx_if.pixel_valid,
             rx_if.pixel_valid ? rx_if.pixel_idx : {IDXW{1'b0}},
             rx_if.pixel_valid ? rx_if.pixel : {BPP{1'b0}}};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_strobe: got %h, expected no strobe", obs);
      end else begin
        exp_v = exp_q.pop_front();
        check("strobe", 64'(obs), 64'(exp_v));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic pulse(input int h, input int l);
    din = 1'b1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(80, 45);
    else   pulse(40, 85);
  endtask

  // Sends the low n bits of v, most significant first.
  task automatic send_bits(input logic [BPP-1:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic gap(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pixel"}, 64'(rx_if.pixel), 64'(0));
    check({tag, "_pixel_valid"}, 64'(rx_if.pixel_valid), 64'(0));
    check({tag, "_pixel_idx"}, 64'(rx_if.pixel_idx), 64'(0));
    check({tag, "_frame_done"}, 64'(rx_if.frame_done), 64'(0));
    check({tag, "_bit_err"}, 64'(rx_if.bit_err), 64'(0));
    check({tag, "_state"}, 64'(rx_if.state), 64'(SYNC));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [BPP-1:0] frame1;
    frame1 = 24'hA53C0F;

    reset_n = 1'b0;
    din     = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;

    // Startup gap: SYNC -> IDLE, no strobes.
    gap(GAP);
    check("state_after_gap", 64'(rx_if.state), 64'(IDLE));

    // Frame 0xA53C0F; last bit sent by hand to check strobe latency.
    exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b1, 6'd0, 24'hA53C0F));
    exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 6'd0, 24'h0));
    send_bits(frame1 >> 1, 23);
    din = 1'b1;
    repeat (80) @(negedge clk);
    din = 1'b0;
    repeat (3) @(negedge clk);
    check("pv_latency_early", 64'(rx_if.pixel_valid), 64'(0));
    @(negedge clk);
    check("pv_latency", 64'(rx_if.pixel_valid), 64'(1));
    gap(GAP);

    // Threshold: 59 -> 0 and 60 -> 1 at MSB-first position 7.
    exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b1, 6'd0, 24'hFEFFFF));
    exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b1, 6'd1, 24'hFFFFFF));
    exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b1, 6'd2, 24'h010000));
    exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 6'd0, 24'h0));
    for (int i = 0; i < BPP; i++) if (i == 7) pulse(59, 66); else send_bit(1'b1);
    for (int i = 0; i < BPP; i++) if (i == 7) pulse(60, 65); else send_bit(1'b1);
    for (int i = 0; i < BPP; i++) if (i == 7) pulse(60, 65); else send_bit(1'b0);
    gap(GAP);

    // Stuck high mid-word: bit_err, back to SYNC, then a mid-stream join.
    exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 6'd0, 24'h0));
    send_bits(24'h000016, 5);
    pulse(150, 20);
    check("state_after_fault", 64'(rx_if.state), 64'(SYNC));
    send_bits(24'h0002D3, 10);
    check("state_midstream", 64'(rx_if.state), 64'(SYNC));
    gap(GAP);

    // Three-pixel frame after recovery.
    exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b1, 6'd0, 24'h112233));
    exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b1, 6'd1, 24'h445566));
    exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b1, 6'd2, 24'h778899));
    exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 6'd0, 24'h0));
    send_bits(24'h112233, 24);
    send_bits(24'h445566, 24);
    send_bits(24'h778899, 24);
    gap(GAP);

    // One pixel then a partial word: bit_err with frame_done, no pixel.
    exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b1, 6'd0, 24'hC0FFEE));
    exp_q.push_back(mk_ev(1'b1, 1'b1, 1'b0, 6'd0, 24'h0));
    send_bits(24'hC0FFEE, 24);
    send_bits(24'h000ABC, 12);
    gap(GAP);

    // Next frame restarts at index 0; reset after 10 bits of its 2nd pixel.
    exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b1, 6'd0, 24'h5A5A5A));
    send_bits(24'h5A5A5A, 24);
    send_bits(24'h0002AA, 10);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_outputs_zero("reset_mid");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Bits right after reset are ignored until a full gap.
    send_bits(24'h0003FF, 10);
    gap(GAP);
    exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b1, 6'd0, 24'h123456));
    exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 6'd0, 24'h0));
    send_bits(24'h123456, 24);
    gap(GAP);

    // Drain: every expected strobe must have been seen.
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Receiver for the WS2812 single-wire pixel protocol, the receiving end of the stream our neopixel strip driver transmits. It oversamples `din` on the system clock, classifies each high pulse as a 0 or 1 bit, packs bits MSB-first into 24-bit pixel words, and detects the latch (reset) gap that ends a frame. It serves as a loopback checker on the hologram board and as the input stage for daisy-chained boards.

## Interface
Parameters:
- `BIT_THRESH`, 60: high-pulse width in cycles at or above which the bit is 1 (0.6 µs at 100 MHz).
- `MAX_HIGH`, 150: high-pulse width in cycles treated as a line fault.
- `LATCH_CYCLES`, 5000: continuous low width in cycles that ends a frame (50 µs).
- `BITS_PER_PIXEL`, 24: bits per pixel word.
- `PX_COUNT_WIDTH`, 6: width of the pixel index.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `din` in 1: raw WS2812 line, asynchronous to `clk`.
- `pixel` out BITS_PER_PIXEL: last complete word, MSB = first bit received.
- `pixel_valid` out 1: one-cycle strobe; `pixel` and `pixel_idx` are valid.
- `pixel_idx` out PX_COUNT_WIDTH: index of `pixel` within the frame, 0 = first.
- `frame_done` out 1: one-cycle strobe at the latch gap.
- `bit_err` out 1: one-cycle strobe on a framing fault.

## Operation
- `din` passes through a 2-flop synchronizer (`s`). Edges are detected against the registered previous `s`.
- One counter `cnt` has width clog2(LATCH_CYCLES+1). It clears on every edge of `s` and saturates at LATCH_CYCLES.
- States:
  - SYNC (reset state). Waits for `s` low for LATCH_CYCLES cycles, then goes to IDLE. Any high resets the wait. This ignores a stream joined mid-frame.
  - IDLE. On a rising edge, goes to HIGH. Holds `pixel_idx` at 0 and `bit_cnt` at 0.
  - HIGH. Counts the high width.
    - On a falling edge, shifts in bit = (`cnt` ≥ BIT_THRESH) and goes to LOW.
    - If `cnt` reaches MAX_HIGH, pulses `bit_err`, discards the partial word, and goes to SYNC.
  - LOW. On a rising edge, goes to HIGH. When `cnt` reaches LATCH_CYCLES, it ends the frame and goes to IDLE.
- Word assembly:
  - `shreg` = {`shreg`[BPP-2:0], bit}.
  - When `bit_cnt` reaches BITS_PER_PIXEL:
    - register `pixel`;
    - pulse `pixel_valid` with the current `pixel_idx`;
    - clear `bit_cnt`;
    - increment `pixel_idx` on the following cycle, wrapping modulo 2^PX_COUNT_WIDTH.
- Frame end (latch in LOW):
  - `frame_done` pulses if at least one bit was received since the last boundary.
  - If `bit_cnt` ≠ 0 (partial word), `bit_err` pulses in the same cycle and the partial word is discarded, with no `pixel_valid`.
  - `pixel_idx` and `bit_cnt` clear.
- `pixel` holds its value between strobes.

## Timing
- Reset values: state = SYNC, `pixel` = 0, `pixel_idx` = 0, `pixel_valid` = 0, `frame_done` = 0, `bit_err` = 0, synchronizer flops = 0.
- Latency:
  - `pixel_valid` is high in the cycle after the third `clk` edge following the edge that first samples the final falling edge of `din` (2 synchronizer + 1 FSM).
  - `frame_done` follows the same path, measured from `s` having been low for LATCH_CYCLES cycles.
- Width measured in `s` domain: a pulse of N cycles in `s` is classified with `cnt` = N at the falling edge. N = BIT_THRESH−1 gives 0; N = BIT_THRESH gives 1.
- Strobes are exactly one cycle. There is no back-pressure; the consumer must accept every strobe.
- The minimum legal low time between bits is 1 cycle of `s`. Shorter glitches are not filtered.
- Reset asserted mid-frame clears all state immediately. After release, the block waits in SYNC for a full latch gap.

## Structure
- Package `ws2812_pkg`:
  - state enum (SYNC, IDLE, HIGH, LOW);
  - default timing constants for 100 MHz (`WS_T_BIT_THRESH`, `WS_T_MAX_HIGH`, `WS_T_LATCH`);
  - `WS_BITS_PER_PIXEL`.
- Sub-module `sync_2ff`: generic 2-flop synchronizer with async active-low reset. Everything else stays in `ws2812_rx`.

## Test plan
- Startup: release reset, `din` low 5000 cycles. Then send 24 bits encoding 0xA53C0F (0 = 40 high/85 low, 1 = 80 high/45 low), then low 5000 cycles. Required: one `pixel_valid` with `pixel` = 0xA53C0F and `pixel_idx` = 0, then one `frame_done`, and `bit_err` never asserted.
- Threshold: single-bit patterns with high widths 59 and 60 cycles inside a word of 1s. Required: decoded bits 0 and 1 respectively.
- Mid-stream join: start toggling valid bits with no preceding latch gap. Required: no strobes until a 5000-cycle low. The following frame of 3 pixels yields `pixel_idx` 0, 1, 2 and one `frame_done`.
- Partial word: 12 bits then latch. Required: `bit_err` and `frame_done` in the same cycle, no `pixel_valid`. The next frame starts at `pixel_idx` 0.
- Stuck high: `din` high 150 cycles mid-word. Required: `bit_err` pulse, return to SYNC, and no output until a new latch gap.
- Reset mid-frame: assert `reset_n` low after 10 bits of a pixel. Required: all outputs 0 on the next edge. The subsequent frame decodes correctly only after a full latch gap.
